// File: rtl/oddr_gearbox_pkg.sv
// rtl/oddr_gearbox_pkg.sv - shared types and constants for the ODDR x2 transmit gearbox
package oddr_gearbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] IDLE_PAT_DEF  = 4'h0;
  localparam logic [3:0] TRAIN_PAT_DEF = 4'hA;

  function automatic int nib_count(input int word_w);
    return word_w / 4;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// rtl/sync_word_fifo.sv - single-clock word FIFO with occupancy count
module sync_word_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       SCLK,
  input  logic                       rst_internal,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A full FIFO refuses writes even when a read frees a slot on the same edge.
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge SCLK) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge SCLK or posedge rst_internal) begin
    if (rst_internal) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/oddrx2_tx_gearbox.sv
// rtl/oddrx2_tx_gearbox.sv - buffers words and slices them into nibbles for the 4:1 ODDR serializer
module oddrx2_tx_gearbox
  import oddr_gearbox_pkg::*;
#(
  parameter int         WORD_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] IDLE_PAT   = IDLE_PAT_DEF,
  parameter logic [3:0] TRAIN_PAT  = TRAIN_PAT_DEF
) (
  input  logic                          SCLK,
  input  logic                          rst_internal,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          train_en,
  input  logic                          clr_underrun,
  output logic                          D0,
  output logic                          D1,
  output logic                          D2,
  output logic                          D3,
  output logic                          tx_active,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int         NIB      = nib_count(WORD_W);
  localparam logic [2:0] LAST_IDX = 3'(NIB - 1);

  logic [WORD_W:0]   fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  state_t            state, next_state;
  logic [2:0]        nib_idx, next_idx;
  logic [WORD_W-1:0] cur_word, next_word;
  logic              cur_last, next_last;
  logic [3:0]        d_q, next_d;
  logic              set_underrun;

  assign in_ready = !fifo_full;
  assign {D3, D2, D1, D0} = d_q;

  sync_word_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .SCLK         (SCLK),
    .rst_internal (rst_internal),
    .wr_en        (in_valid),
    .din          ({in_last, in_data}),
    .rd_en        (pop),
    .dout         (fifo_dout),
    .level        (fifo_level),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // nib_idx tracks the nibble currently on D, so the last-nibble decision is made on that edge.
  always_comb begin
    next_state   = state;
    next_idx     = nib_idx;
    next_word    = cur_word;
    next_last    = cur_last;
    next_d       = IDLE_PAT;
    pop          = 1'b0;
    set_underrun = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_word  = fifo_dout[WORD_W-1:0];
          next_last  = fifo_dout[WORD_W];
          next_idx   = 3'd0;
          next_d     = fifo_dout[3:0];
          next_state = ST_DATA;
        end else if (train_en) begin
          next_d     = TRAIN_PAT;
          next_state = ST_TRAIN;
        end
      end
      ST_TRAIN: begin
        if (train_en) begin
          next_d = TRAIN_PAT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (nib_idx != LAST_IDX) begin
          next_idx = nib_idx + 3'd1;
          next_d   = 4'(cur_word >> {next_idx, 2'b00});
        end else if (cur_last) begin
          next_state = ST_IDLE;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          next_word = fifo_dout[WORD_W-1:0];
          next_last = fifo_dout[WORD_W];
          next_idx  = 3'd0;
          next_d    = fifo_dout[3:0];
        end else begin
          set_underrun = 1'b1;
          next_state   = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or posedge rst_internal) begin
    if (rst_internal) begin
      state     <= ST_IDLE;
      nib_idx   <= 3'd0;
      cur_word  <= '0;
      cur_last  <= 1'b0;
      d_q       <= IDLE_PAT;
      tx_active <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= next_state;
      nib_idx   <= next_idx;
      cur_word  <= next_word;
      cur_last  <= next_last;
      d_q       <= next_d;
      tx_active <= (next_state == ST_DATA);
      if (set_underrun)      underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule
